// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the 8 x 32-bit register bank and its write path.
package reg_file_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int NUM_REGS   = 8;
   localparam int ADDR_WIDTH = 3;

   // One queued write request: target register and the word to store there.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wr_req_t;

   // Address to one-hot register select. An address beyond NUM_REGS-1 decodes
   // to all zeros, so such a write reaches no register.
   function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_WIDTH-1:0] addr);
      logic [NUM_REGS-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(addr) == i) oh[i] = 1'b1;
      end
      return oh;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small in-order FIFO with synchronous flush. The whole storage array and a
// per-slot valid vector are exported so a consumer can scan what is queued.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH+1)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   input  logic [WIDTH-1:0]             wdata_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic [CW-1:0]                count_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [DEPTH-1:0][WIDTH-1:0] entries_o,
   output logic [DEPTH-1:0]             valid_o
);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q;
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        do_push, do_pop;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign entries_o = mem_q;

   // Flush wins over both directions; push/pop are also self-guarded.
   assign do_push = push_i && !full_o  && !flush_i;
   assign do_pop  = pop_i  && !empty_o && !flush_i;

   // Next pointer/count state. DEPTH is a power of two, so pointer
   // increments wrap modulo DEPTH on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: a slot is only observed while valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // A slot is live when its distance past the read pointer is below count.
   always_comb begin
      logic [PW-1:0] off;
      off     = '0;
      valid_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off        = PW'(i) - rd_ptr_q;
         valid_o[i] = (CW'(off) < count_q);
      end
   end

endmodule

// File: rtl/reg_file_write_queue.sv
// Write-side front end of the register bank: buffers requests in a FIFO,
// drains one per cycle into a registered one-hot enable plus data word, and
// reports which registers still have uncommitted writes.
module reg_file_write_queue
   import reg_file_pkg::*;
#(
   parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
   parameter int NUM_REGS   = reg_file_pkg::NUM_REGS,
   parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic                         drain_hold,
   input  logic                         flush,
   output logic [NUM_REGS-1:0]          en,
   output logic [DATA_WIDTH-1:0]        d_in,
   output logic [NUM_REGS-1:0]          pending,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int REQW = $bits(wr_req_t);

   wr_req_t                     req_in;
   wr_req_t                     head;
   logic [REQW-1:0]             head_raw;
   logic [DEPTH-1:0][REQW-1:0] fifo_entries;
   logic [DEPTH-1:0]            fifo_valid;
   logic                        push_w, pop_w;
   logic [NUM_REGS-1:0]         en_q, en_d;
   logic [DATA_WIDTH-1:0]       d_in_q, d_in_d;
   logic [NUM_REGS-1:0]         queued_mask;

   // Ready looks only at pre-edge full, so a full queue refuses a push even
   // on a cycle where it also pops.
   assign wr_ready = !full && !flush && reset_n;
   assign push_w   = wr_valid && wr_ready;
   assign pop_w    = !empty && !drain_hold && !flush;

   assign req_in.addr = wr_addr;
   assign req_in.data = wr_data;
   assign head        = wr_req_t'(head_raw);

   sync_fifo #(
      .WIDTH (REQW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push_i    (push_w),
      .pop_i     (pop_w),
      .flush_i   (flush),
      .wdata_i   (req_in),
      .rdata_o   (head_raw),
      .count_o   (count),
      .full_o    (full),
      .empty_o   (empty),
      .entries_o (fifo_entries),
      .valid_o   (fifo_valid)
   );

   // Popped head becomes the next bank write; idle cycles drop en but keep d_in.
   always_comb begin
      en_d   = '0;
      d_in_d = d_in_q;
      if (pop_w) begin
         en_d   = onehot(head.addr);
         d_in_d = head.data;
      end
   end

   // Bank-facing output register; no same-cycle bypass from the request port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q   <= '0;
         d_in_q <= '0;
      end else begin
         en_q   <= en_d;
         d_in_q <= d_in_d;
      end
   end

   assign en   = en_q;
   assign d_in = d_in_q;

   // Registers targeted by any live queue slot; the in-flight en is added
   // below so the bit holds until the bank has actually committed.
   always_comb begin
      wr_req_t e;
      e           = '0;
      queued_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         e = wr_req_t'(fifo_entries[i]);
         if (fifo_valid[i]) queued_mask = queued_mask | onehot(e.addr);
      end
   end

   assign pending = queued_mask | en_q;

endmodule

// File: tb/tb_reg_file_write_queue.sv
// Directed and random checks of the register-file write queue against a
// queue-based reference model and a model of the downstream bank.
module tb_reg_file_write_queue;

   localparam int NR    = 8;
   localparam int DW    = 32;
   localparam int AW    = 3;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          drain_hold = 1'b0;
   logic          flush = 1'b0;
   logic          wr_ready;
   logic [NR-1:0] en, pending;
   logic [DW-1:0] d_in;
   logic [2:0]    count;
   logic          empty, full;

   always #5 clk = ~clk;

   reg_file_write_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .drain_hold (drain_hold),
      .flush      (flush),
      .en         (en),
      .d_in       (d_in),
      .pending    (pending),
      .count      (count),
      .empty      (empty),
      .full       (full)
   );

   // Bank driven by the DUT outputs, as the real register file would be.
   logic [DW-1:0] bank [NR] = '{default: '0};
   always @(posedge clk) begin
      for (int i = 0; i < NR; i++) if (en[i]) bank[i] <= d_in;
   end

   // Reference model state.
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } req_t;
   req_t          mq[$];
   logic [NR-1:0] m_en = '0;
   logic [DW-1:0] m_d = '0;
   logic [DW-1:0] m_bank [NR] = '{default: '0};

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR-1:0] exp_pending();
      logic [NR-1:0] r;
      r = m_en;
      foreach (mq[i]) r = r | (NR'(1) << mq[i].a);
      return r;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".en"},      32'(en),      32'(m_en));
      chk({tag, ".d_in"},    d_in,         m_d);
      chk({tag, ".count"},   32'(count),   32'(mq.size()));
      chk({tag, ".empty"},   32'(empty),   32'(mq.size() == 0));
      chk({tag, ".full"},    32'(full),    32'(mq.size() == DEPTH));
      chk({tag, ".pending"}, 32'(pending), 32'(exp_pending()));
   endtask

   // One clock cycle: drive inputs, check ready, advance model across the edge.
   task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic h, input logic f, output logic acc);
      logic m_ready, m_pop;
      req_t hd;
      wr_valid = v; wr_addr = a; wr_data = d; drain_hold = h; flush = f;
      #1;
      m_ready = (mq.size() < DEPTH) && !f;
      chk("wr_ready", 32'(wr_ready), 32'(m_ready));
      acc = v && m_ready;
      @(posedge clk);
      for (int i = 0; i < NR; i++) if (m_en[i]) m_bank[i] = m_d;
      m_pop = (mq.size() > 0) && !h && !f;
      if (f) begin
         mq.delete();
         m_en = '0;
      end else if (m_pop) begin
         hd   = mq.pop_front();
         m_en = NR'(1) << hd.a;
         m_d  = hd.d;
      end else begin
         m_en = '0;
      end
      if (acc) mq.push_back('{a, d});
      #1;
      check_outputs("cyc");
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, acc);
   endtask

   initial begin
      logic acc;
      logic done;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst.wr_ready", 32'(wr_ready), 32'd0);
      check_outputs("rst");
      reset_n = 1'b1;
      #1;
      chk("rel.wr_ready", 32'(wr_ready), 32'd1);

      // Single write, latency and commit.
      step(1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 1'b0, acc);
      chk("single.pend_k", 32'(pending), 32'h20);
      idle(1);
      chk("single.en_k1", 32'(en), 32'h20);
      chk("single.d_k1", d_in, 32'hDEADBEEF);
      idle(1);
      chk("single.en_k2", 32'(en), 32'h0);
      chk("single.pend_k2", 32'(pending), 32'h0);
      chk("single.bank5", bank[5], 32'hDEADBEEF);

      // Back-pressure: fill under hold, fifth request waits.
      for (int i = 0; i < 4; i++) step(1'b1, AW'(i), 32'h100 + i, 1'b1, 1'b0, acc);
      chk("bp.full", 32'(full), 32'd1);
      chk("bp.count", 32'(count), 32'd4);
      step(1'b1, 3'd4, 32'h104, 1'b1, 1'b0, acc);
      chk("bp.held", 32'(acc), 32'd0);
      done = 1'b0;
      for (int t = 0; t < 10 && !done; t++) begin
         step(1'b1, 3'd4, 32'h104, 1'b0, 1'b0, acc);
         done = acc;
      end
      chk("bp.accepted", 32'(done), 32'd1);
      idle(5);
      chk("bp.bank4", bank[4], 32'h104);

      // Repeated writes to one register: last one wins.
      step(1'b1, 3'd2, 32'h1, 1'b0, 1'b0, acc);
      step(1'b1, 3'd2, 32'h2, 1'b0, 1'b0, acc);
      idle(4);
      chk("same.bank2", bank[2], 32'h2);

      // Flush with three queued entries.
      step(1'b1, 3'd1, 32'hA, 1'b1, 1'b0, acc);
      step(1'b1, 3'd3, 32'hB, 1'b1, 1'b0, acc);
      step(1'b1, 3'd6, 32'hC, 1'b1, 1'b0, acc);
      step(1'b1, 3'd7, 32'hD, 1'b1, 1'b1, acc);
      chk("flush.count", 32'(count), 32'd0);
      chk("flush.pend", 32'(pending), 32'd0);
      idle(3);
      chk("flush.bank6", bank[6], 32'h0);

      // Push and pop on the same edge at count 2.
      step(1'b1, 3'd0, 32'h50, 1'b1, 1'b0, acc);
      step(1'b1, 3'd1, 32'h51, 1'b1, 1'b0, acc);
      step(1'b1, 3'd2, 32'h52, 1'b0, 1'b0, acc);
      chk("pp.count", 32'(count), 32'd2);
      idle(4);
      chk("pp.bank2", bank[2], 32'h52);

      // Asynchronous reset mid-run while en is active.
      step(1'b1, 3'd3, 32'h33, 1'b0, 1'b0, acc);
      idle(1);
      chk("arst.en_before", 32'(en), 32'h08);
      #1 reset_n = 1'b0;
      #1;
      chk("arst.en", 32'(en), 32'h0);
      chk("arst.d_in", d_in, 32'h0);
      chk("arst.pend", 32'(pending), 32'h0);
      chk("arst.count", 32'(count), 32'h0);
      chk("arst.wr_ready", 32'(wr_ready), 32'h0);
      mq.delete();
      m_en = '0;
      m_d  = '0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("arst.release", 32'(wr_ready), 32'd1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, AW'($urandom), DW'($urandom),
              ($urandom % 10) < 3, ($urandom % 20) == 0, acc);
      end
      idle(8);
      for (int i = 0; i < NR; i++) chk($sformatf("bank%0d", i), bank[i], m_bank[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
